puf_resp_voter: RTL and testbench



---
 rtl/puf_resp_voter.sv | 169 ++++++++++++++++
 tb/tb_puf_resp_voter.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/puf_resp_voter.sv
`default_nettype none
// ============================================================================
//  Module   : puf_resp_voter
//  Purpose  : Evaluates a bistable-ring PUF SAMPLES times per challenge and
//             returns a per-bit majority vote over a valid/ready handshake.
//  Options  : PUF_VOTER_STABILITY_EN - when defined, unstable_o flags bits
//             whose samples disagreed; otherwise unstable_o is tied to zero.
//  Revision : 1.0 - initial release
// ============================================================================
module puf_resp_voter #(
  parameter int WIDTH   = 32,
  parameter int SAMPLES = 7,
  parameter int RST_CYC = 4,
  parameter int SETTLE  = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start_i,
  input  logic [WIDTH-1:0] challenge_i,
  output logic [WIDTH-1:0] puf_challenge_o,
  output logic             puf_reset_o,
  input  logic [WIDTH-1:0] puf_rsp_i,
  output logic             busy_o,
  output logic             resp_valid_o,
  input  logic             resp_ready_i,
  output logic [WIDTH-1:0] resp_o,
  output logic [WIDTH-1:0] unstable_o
);

  localparam int CNT_W  = $clog2(SAMPLES + 1);
  localparam int PH_MAX = (RST_CYC > SETTLE) ? RST_CYC : SETTLE;
  localparam int PH_W   = $clog2(PH_MAX + 1);

  localparam logic [PH_W-1:0]  C_RST_LAST    = PH_W'(RST_CYC - 1);
  localparam logic [PH_W-1:0]  C_SETTLE_LAST = PH_W'(SETTLE - 1);
  localparam logic [CNT_W-1:0] C_IDX_LAST    = CNT_W'(SAMPLES - 1);
  localparam logic [CNT_W-1:0] C_HALF        = CNT_W'(SAMPLES / 2);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_RST    = 3'd1;
  localparam logic [2:0] S_SETTLE = 3'd2;
  localparam logic [2:0] S_SAMPLE = 3'd3;
  localparam logic [2:0] S_DONE   = 3'd4;

  logic [2:0]       state_q, state_d;
  logic [PH_W-1:0]  ph_q;
  logic [CNT_W-1:0] idx_q;
  logic [WIDTH-1:0] chal_q;
  logic [WIDTH-1:0] sync1_q, sync2_q;
  logic [WIDTH-1:0] resp_q;
  logic             valid_q;
  logic [WIDTH-1:0] vote_w;
  logic             accept_w;

  assign accept_w = (state_q == S_IDLE) && start_i;

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= S_IDLE;
    else          state_q <= state_d;
  end

  // Next-state logic: phase counter paces RST/SETTLE, index counts evaluations
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (start_i) state_d = S_RST;
      S_RST:    if (ph_q == C_RST_LAST) state_d = S_SETTLE;
      S_SETTLE: if (ph_q == C_SETTLE_LAST) state_d = S_SAMPLE;
      S_SAMPLE: state_d = (idx_q == C_IDX_LAST) ? S_DONE : S_RST;
      S_DONE:   if (valid_q && resp_ready_i) state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // Outputs decoded from state; the ring is held in reset whenever idle
  always_comb begin
    busy_o      = (state_q != S_IDLE);
    puf_reset_o = (state_q == S_IDLE) || (state_q == S_RST);
  end

  // Phase counter restarts on every state change, runs only in timed states
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ph_q <= '0;
    end else if (state_d != state_q) begin
      ph_q <= '0;
    end else if (state_q == S_RST || state_q == S_SETTLE) begin
      ph_q <= ph_q + 1'b1;
    end
  end

  // Challenge latch and evaluation index
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      chal_q <= '0;
      idx_q  <= '0;
    end else if (accept_w) begin
      chal_q <= challenge_i;
      idx_q  <= '0;
    end else if (state_q == S_SAMPLE && idx_q != C_IDX_LAST) begin
      idx_q <= idx_q + 1'b1;
    end
  end

  // Two-flop synchronizer for the asynchronous ring response
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= puf_rsp_i;
      sync2_q <= sync1_q;
    end
  end

  // Per-bit ones counters and votes; counters never exceed SAMPLES
  for (genvar b = 0; b < WIDTH; b++) begin : g_bit
    logic [CNT_W-1:0] cnt_q;

    // Clear on accept, count synchronized ones in each SAMPLE cycle
    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)                  cnt_q <= '0;
      else if (accept_w)             cnt_q <= '0;
      else if (state_q == S_SAMPLE)  cnt_q <= cnt_q + CNT_W'(sync2_q[b]);
    end

    assign vote_w[b] = (cnt_q > C_HALF);
  end

  // Result capture on DONE entry, valid held until the handshake edge
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      resp_q  <= '0;
      valid_q <= 1'b0;
    end else if (state_q == S_DONE && !valid_q) begin
      resp_q  <= vote_w;
      valid_q <= 1'b1;
    end else if (valid_q && resp_ready_i) begin
      valid_q <= 1'b0;
    end
  end

`ifdef PUF_VOTER_STABILITY_EN
  localparam logic [CNT_W-1:0] C_ALL = CNT_W'(SAMPLES);
  logic [WIDTH-1:0] unst_w;
  logic [WIDTH-1:0] unst_q;

  for (genvar u = 0; u < WIDTH; u++) begin : g_unst
    assign unst_w[u] = (g_bit[u].cnt_q != '0) && (g_bit[u].cnt_q != C_ALL);
  end

  // Non-unanimity flags captured alongside the vote
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)                       unst_q <= '0;
    else if (state_q == S_DONE && !valid_q) unst_q <= unst_w;
  end

  assign unstable_o = unst_q;
`else
  assign unstable_o = '0;
`endif

  assign puf_challenge_o = chal_q;
  assign resp_o          = resp_q;
  assign resp_valid_o    = valid_q;

endmodule
`default_nettype wire

// File: tb/tb_puf_resp_voter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_puf_resp_voter
//  Purpose  : Self-checking bench for puf_resp_voter with a majority-vote
//             reference model; honours PUF_VOTER_STABILITY_EN like the DUT.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_puf_resp_voter;

  localparam int W   = 32;
  localparam int S   = 7;
  localparam int RC  = 4;
  localparam int ST  = 16;
  localparam int PER = RC + ST + 1;
  localparam int LAT = S * PER + 1;

  logic         clk = 1'b0;
  logic         reset_n;
  logic         start_i;
  logic [W-1:0] challenge_i;
  logic [W-1:0] puf_challenge_o;
  logic         puf_reset_o;
  logic [W-1:0] puf_rsp_i;
  logic         busy_o;
  logic         resp_valid_o;
  logic         resp_ready_i;
  logic [W-1:0] resp_o;
  logic [W-1:0] unstable_o;

  int checks = 0;
  int errors = 0;

  logic [W-1:0] smp [S];
  logic [W-1:0] exp_resp;
  logic [W-1:0] exp_unst;

  puf_resp_voter #(.WIDTH(W), .SAMPLES(S), .RST_CYC(RC), .SETTLE(ST)) dut (
    .clk             (clk),
    .reset_n         (reset_n),
    .start_i         (start_i),
    .challenge_i     (challenge_i),
    .puf_challenge_o (puf_challenge_o),
    .puf_reset_o     (puf_reset_o),
    .puf_rsp_i       (puf_rsp_i),
    .busy_o          (busy_o),
    .resp_valid_o    (resp_valid_o),
    .resp_ready_i    (resp_ready_i),
    .resp_o          (resp_o),
    .unstable_o      (unstable_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%h expected 0x%h", tag, obs, exp);
    end
  endtask

  // Reference: count ones per bit over the sample set, vote and flag disagreement
  task automatic compute_expected();
    int ones;
    for (int b = 0; b < W; b++) begin
      ones = 0;
      for (int k = 0; k < S; k++) if (smp[k][b]) ones++;
      exp_resp[b] = (2 * ones > S);
`ifdef PUF_VOTER_STABILITY_EN
      exp_unst[b] = (ones != 0) && (ones != S);
`else
      exp_unst[b] = 1'b0;
`endif
    end
  endtask

  // Starts one evaluation (caller sits 1 time unit after a rising edge),
  // feeds smp[k] during evaluation k and checks latency, pulses and result.
  task automatic run_eval(input logic [W-1:0] chal, input string tag);
    int   n, run, falls, badruns, idle_cyc;
    logic prev;
    compute_expected();
    start_i     = 1'b1;
    challenge_i = chal;
    puf_rsp_i   = smp[0];
    @(posedge clk); #1;
    start_i     = 1'b0;
    challenge_i = $urandom;
    check({tag, "_busy_start"}, W'(busy_o), W'(1));
    check({tag, "_pufrst_start"}, W'(puf_reset_o), W'(1));
    n = 0; run = 1; falls = 0; badruns = 0; idle_cyc = 0;
    prev = puf_reset_o;
    while (!resp_valid_o && n < 400) begin
      @(posedge clk); #1;
      n++;
      if ((n % PER) == 0 && (n / PER) < S) puf_rsp_i = smp[n / PER];
      if (prev && !puf_reset_o) begin
        falls++;
        if (run != RC) badruns++;
        run = 0;
      end
      if (puf_reset_o && busy_o) run++;
      if (!busy_o) idle_cyc++;
      prev = puf_reset_o;
    end
    check({tag, "_latency"}, W'(n), W'(LAT));
    check({tag, "_reset_falls"}, W'(falls), W'(S));
    check({tag, "_reset_width_bad"}, W'(badruns), W'(0));
    check({tag, "_busy_drop"}, W'(idle_cyc), W'(0));
    check({tag, "_challenge"}, puf_challenge_o, chal);
    check({tag, "_resp"}, resp_o, exp_resp);
    check({tag, "_unstable"}, unstable_o, exp_unst);
  endtask

  // Holds ready low while disturbing inputs, then completes the handshake
  task automatic handshake(input int hold, input string tag);
    int bad;
    bad = 0;
    for (int c = 0; c < hold; c++) begin
      start_i   = 1'($urandom_range(0, 1));
      puf_rsp_i = $urandom;
      @(posedge clk); #1;
      if (resp_valid_o !== 1'b1 || busy_o !== 1'b1 ||
          resp_o !== exp_resp || unstable_o !== exp_unst) bad++;
    end
    check({tag, "_hold_stable"}, W'(bad), W'(0));
    start_i      = 1'b1;
    resp_ready_i = 1'b1;
    @(posedge clk); #1;
    resp_ready_i = 1'b0;
    start_i      = 1'b0;
    check({tag, "_valid_drop"}, W'(resp_valid_o), W'(0));
    check({tag, "_busy_drop_hs"}, W'(busy_o), W'(0));
    check({tag, "_resp_kept"}, resp_o, exp_resp);
  endtask

  initial begin
    logic [W-1:0] base, noise;
    reset_n      = 1'b0;
    start_i      = 1'b0;
    challenge_i  = '0;
    puf_rsp_i    = '0;
    resp_ready_i = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", W'(busy_o), W'(0));
    check("rst_valid", W'(resp_valid_o), W'(0));
    check("rst_pufrst", W'(puf_reset_o), W'(1));
    check("rst_resp", resp_o, W'(0));
    check("rst_unst", unstable_o, W'(0));
    check("rst_chal", puf_challenge_o, W'(0));
    reset_n = 1'b1;
    @(posedge clk); #1;
    check("idle_pufrst", W'(puf_reset_o), W'(1));

    // Constant response with backpressure
    for (int k = 0; k < S; k++) smp[k] = 32'hA5A5_0F0F;
    run_eval(32'h1234_5678, "const");
    handshake(20, "const");

    // Alternating noisy bit 0, then back-to-back majority-low case
    for (int k = 0; k < S; k++) smp[k] = ((k % 2) == 0) ? W'(1) : W'(0);
    run_eval(32'hCAFE_0001, "noisy");
    handshake(0, "noisy");
    for (int k = 0; k < S; k++) smp[k] = (k < 3) ? W'(1) : W'(0);
    run_eval(32'hCAFE_0002, "minor");
    handshake(2, "minor");

    // Reset 60 cycles into an evaluation
    for (int k = 0; k < S; k++) smp[k] = $urandom;
    start_i = 1'b1; challenge_i = 32'h0BAD_F00D; puf_rsp_i = smp[0];
    @(posedge clk); #1;
    start_i = 1'b0;
    repeat (59) @(posedge clk);
    #1;
    reset_n = 1'b0;
    #1;
    check("midrst_busy", W'(busy_o), W'(0));
    check("midrst_valid", W'(resp_valid_o), W'(0));
    check("midrst_pufrst", W'(puf_reset_o), W'(1));
    check("midrst_resp", resp_o, W'(0));
    check("midrst_unst", unstable_o, W'(0));
    check("midrst_chal", puf_challenge_o, W'(0));
    @(posedge clk); #1;
    reset_n = 1'b1;
    @(posedge clk); #1;
    check("midrst_idle", W'(busy_o), W'(0));
    run_eval(32'h5555_AAAA, "restart");
    handshake(1, "restart");

    // Randomized evaluations, mostly stable bits with a few noisy ones
    for (int t = 0; t < 5; t++) begin
      base  = $urandom;
      noise = $urandom & $urandom & $urandom;
      for (int k = 0; k < S; k++) smp[k] = base ^ (W'($urandom) & noise);
      run_eval($urandom, "rand");
      handshake(int'($urandom_range(0, 5)), "rand");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    errors++;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
